data_mem_responder: RTL and testbench

Wait-state data-memory responder for the 16-bit pipeline. It is the target side of the memory stage's load/store accesses: it accepts one word request at a time, models `WAIT_STATES` cycles of backing-store latency, and performs the array access. It then returns an acknowledge (plus read data for loads) while driving `stall` to the hazard unit so the pipeline holds the requesting instruction until the access completes.

---
 rtl/data_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Target-side responder for the memory stage of the 16-bit pipeline. It takes
// one word load/store request at a time and models WAIT_STATES cycles of
// backing-store latency. It then performs the array access and returns a
// one-cycle acknowledge (with read data for loads). While the access is in
// flight it asks the hazard unit to hold the pipeline.
//
// Parameters:
//   DEPTH_LOG2  - word array depth is 2**DEPTH_LOG2; upper address bits alias
//   WAIT_STATES - extra latency cycles per access (0..15)
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   req_valid   in   memory stage presents an access (held until stall drops)
//   req_we      in   1 = store, 0 = load
//   req_addr    in   16-bit word address
//   req_wdata   in   16-bit store data
//   req_ready   out  responder can accept a request this cycle
//   resp_valid  out  one-cycle acknowledge for every access
//   resp_rdata  out  load data, valid with resp_valid for a load
//   stall       out  pipeline hold request to the hazard unit
//
// Optional feature (macro DMEM_RESP_CYCCNT_EN):
//   Adds a 16-bit free-running cycle counter mapped at address 16'hFFFF.
//   A load there returns the counter value. A store there reloads the
//   counter. Neither access touches the array.
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        stall
);

  localparam int Depth = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } stateT;

  stateT state;
  stateT nextState;

  logic [3:0]            cnt;
  logic                  capWe;
  logic [DEPTH_LOG2-1:0] capIdx;
  logic [15:0]           capWdata;

  logic                  accept;
  logic                  doAccess;
  logic                  memWrite;
  logic [15:0]           loadData;

  logic [15:0] mem [0:Depth-1];

`ifdef DMEM_RESP_CYCCNT_EN
  logic        capIsCnt;
  logic [15:0] cycCnt;
`else
  logic        unusedAddrHi;

  // Upper address bits only matter for the counter window; without it they
  // are deliberately dropped so addresses alias modulo the array depth.
  assign unusedAddrHi = ^(req_addr >> DEPTH_LOG2);
`endif

  // A request is taken only in IDLE. DONE never re-accepts the still-visible
  // completed request. The array access happens on the edge that leaves WAIT
  // with the countdown exhausted.
  assign accept   = (state == IDLE) && req_valid;
  assign doAccess = (state == WAIT) && (cnt == 4'd0);

  // State register; reset drops any pending access immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and handshake outputs. stall covers the presentation cycle
  // and every WAIT cycle, and is low in DONE so the pipeline advances on the
  // edge that returns to IDLE.
  always_comb begin
    nextState  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    stall      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = req_valid;
        if (req_valid) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 4'd0) begin
          nextState = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        nextState  = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // Request capture and wait-state countdown. Once captured, the access
  // completes from these registers even if the requester misbehaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= 4'd0;
      capWe    <= 1'b0;
      capIdx   <= '0;
      capWdata <= 16'h0000;
    end else if (accept) begin
      cnt      <= 4'(WAIT_STATES);
      capWe    <= req_we;
      capIdx   <= req_addr[DEPTH_LOG2-1:0];
      capWdata <= req_wdata;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef DMEM_RESP_CYCCNT_EN
  // Remember whether the captured request targets the counter window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capIsCnt <= 1'b0;
    end else if (accept) begin
      capIsCnt <= (req_addr == 16'hFFFF);
    end
  end

  // Free-running cycle counter. A store to the counter window reloads it
  // and it resumes counting from the stored value on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycCnt <= 16'h0000;
    end else if (doAccess && capWe && capIsCnt) begin
      cycCnt <= capWdata;
    end else begin
      cycCnt <= cycCnt + 16'd1;
    end
  end

  assign memWrite = doAccess && capWe && !capIsCnt;
  assign loadData = capIsCnt ? cycCnt : mem[capIdx];
`else
  assign memWrite = doAccess && capWe;
  assign loadData = mem[capIdx];
`endif

  // Backing array. It is intentionally not reset. A store cut short by reset
  // never reaches this write because reset forces the FSM out of WAIT.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem[capIdx] <= capWdata;
    end
  end

  // Load data register. Stores leave the last load result in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= 16'h0000;
    end else if (doAccess && !capWe) begin
      resp_rdata <= loadData;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. One instance uses the default
// two wait states and a second instance uses zero wait states. A table of
// load/store vectors is replayed against the first instance. Hand-written
// sequences cover back-to-back requests, reset in the middle of an access,
// the zero-wait-state timing and, when DMEM_RESP_CYCCNT_EN is defined, the
// cycle counter window.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        dValid, dWe, dReady, dRespValid, dStall;
  logic [15:0] dAddr, dWdata, dRdata;

  logic        zValid, zWe, zReady, zRespValid, zStall;
  logic [15:0] zAddr, zWdata, zRdata;

  int tests = 0;
  int fails = 0;
  int edgeCnt = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRdata;
    string       name;
  } vecT;

  vecT vecs[7];

  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (dValid),
    .req_we    (dWe),
    .req_addr  (dAddr),
    .req_wdata (dWdata),
    .req_ready (dReady),
    .resp_valid(dRespValid),
    .resp_rdata(dRdata),
    .stall     (dStall)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dutZero (
    .clk       (clk),
    .reset     (reset),
    .req_valid (zValid),
    .req_we    (zWe),
    .req_addr  (zAddr),
    .req_wdata (zWdata),
    .req_ready (zReady),
    .resp_valid(zRespValid),
    .resp_rdata(zRdata),
    .stall     (zStall)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic driveReq(input bit z, input logic v, input logic we,
                          input logic [15:0] a, input logic [15:0] d);
    if (z) begin
      zValid = v; zWe = we; zAddr = a; zWdata = d;
    end else begin
      dValid = v; dWe = we; dAddr = a; dWdata = d;
    end
  endtask

  // Presents one request at a negedge and samples each cycle 1ns later.
  // Cycle 0 is the presentation cycle. The request is withdrawn during the
  // DONE cycle, so the next call presents in the first IDLE cycle.
  task automatic applyStimulus(input bit z, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, output logic [15:0] rdata,
                               output int stallCycles, output int respCycle,
                               output int accessEdge);
    bit done;
    done        = 1'b0;
    stallCycles = 0;
    respCycle   = -1;
    accessEdge  = 0;
    rdata       = 16'h0000;
    @(negedge clk);
    driveReq(z, 1'b1, we, addr, wdata);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (z ? zStall : dStall) stallCycles++;
      if (z ? zRespValid : dRespValid) begin
        respCycle  = cyc;
        rdata      = z ? zRdata : dRdata;
        accessEdge = edgeCnt;
        done       = 1'b1;
        driveReq(z, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checkOutput("respTimeout", 32'd0, 32'd1);
      driveReq(z, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    int          stallCycles, respCycle, eA, eB, pulses;

    // Stores expect resp_rdata to still hold the previous load result.
    vecs[0] = '{1'b1, 16'h0005, 16'h1234, 16'h0000, "store5"};
    vecs[1] = '{1'b0, 16'h0005, 16'h0000, 16'h1234, "load5"};
    vecs[2] = '{1'b1, 16'h0403, 16'hBEEF, 16'h1234, "storeAlias"};
    vecs[3] = '{1'b0, 16'h0003, 16'h0000, 16'hBEEF, "loadAlias"};
    vecs[4] = '{1'b1, 16'h0020, 16'h1111, 16'hBEEF, "store20"};
    vecs[5] = '{1'b0, 16'h0020, 16'h0000, 16'h1111, "load20"};
    vecs[6] = '{1'b0, 16'h0005, 16'h0000, 16'h1234, "reload5"};

    reset = 1'b1;
    driveReq(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    driveReq(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Reset values.
    #12;
    checkOutput("rstReady", 32'(dReady), 32'd1);
    checkOutput("rstRespValid", 32'(dRespValid), 32'd0);
    checkOutput("rstRdata", 32'(dRdata), 32'h0000);
    checkOutput("rstStallLow", 32'(dStall), 32'd0);
    dValid = 1'b1;
    #1;
    checkOutput("rstStallFollowsValid", 32'(dStall), 32'd1);
    dValid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Table-driven accesses on the two-wait-state instance.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd,
                    stallCycles, respCycle, eA);
      checkOutput({vecs[i].name, ".rdata"}, 32'(rd), 32'(vecs[i].expRdata));
      checkOutput({vecs[i].name, ".stallCycles"}, 32'(stallCycles), 32'd4);
      checkOutput({vecs[i].name, ".respCycle"}, 32'(respCycle), 32'd4);
    end

    // Back-to-back with req_valid held high: store 0x00AA then load it back.
    // First access: DONE in cycle 4; second presented in cycle 5 (IDLE),
    // WAIT in cycles 6..8, DONE in cycle 9.
    pulses = 0;
    @(negedge clk);
    driveReq(1'b0, 1'b1, 1'b1, 16'h0010, 16'h00AA);
    for (int c = 0; c < 14; c++) begin
      #1;
      if (dRespValid) pulses++;
      if (c == 4) begin
        checkOutput("b2b.firstResp", 32'(dRespValid), 32'd1);
        checkOutput("b2b.readyInDone", 32'(dReady), 32'd0);
        driveReq(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
      end
      if (c == 5) begin
        checkOutput("b2b.readyInIdle", 32'(dReady), 32'd1);
        checkOutput("b2b.stallInIdle", 32'(dStall), 32'd1);
      end
      if (c == 9) begin
        checkOutput("b2b.secondResp", 32'(dRespValid), 32'd1);
        checkOutput("b2b.rdata", 32'(dRdata), 32'h00AA);
        driveReq(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
      @(negedge clk);
    end
    checkOutput("b2b.pulses", 32'(pulses), 32'd2);

    // Reset during the WAIT of a store that must be dropped.
    @(negedge clk);
    driveReq(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    @(negedge clk);
    #1;
    checkOutput("midRst.inWait", 32'(dReady), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("midRst.ready", 32'(dReady), 32'd1);
    checkOutput("midRst.respValid", 32'(dRespValid), 32'd0);
    checkOutput("midRst.rdata", 32'(dRdata), 32'h0000);
    checkOutput("midRst.stall", 32'(dStall), 32'd1);
    driveReq(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000, rd, stallCycles, respCycle, eA);
    checkOutput("midRst.load20", 32'(rd), 32'h1111);

    // Zero wait states: stall for 2 cycles, response in the cycle after the access edge.
    applyStimulus(1'b1, 1'b1, 16'h0001, 16'h7777, rd, stallCycles, respCycle, eA);
    checkOutput("w0.storeStall", 32'(stallCycles), 32'd2);
    checkOutput("w0.storeResp", 32'(respCycle), 32'd2);
    applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000, rd, stallCycles, respCycle, eA);
    checkOutput("w0.loadStall", 32'(stallCycles), 32'd2);
    checkOutput("w0.loadResp", 32'(respCycle), 32'd2);
    checkOutput("w0.rdata", 32'(rd), 32'h7777);

`ifdef DMEM_RESP_CYCCNT_EN
    // The counter holds 0xFFF0 after the store's access edge eA and gains one
    // per edge. The load samples it just before its own access edge eB.
    applyStimulus(1'b0, 1'b1, 16'h03FF, 16'hA5A5, rd, stallCycles, respCycle, eA);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFF0, rd, stallCycles, respCycle, eA);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, rd, stallCycles, respCycle, eB);
    checkOutput("cyc.value", 32'(rd), 32'(16'(32'hFFF0 + 32'(eB - eA - 1))));
    applyStimulus(1'b0, 1'b0, 16'h03FF, 16'h0000, rd, stallCycles, respCycle, eA);
    checkOutput("cyc.arrayUntouched", 32'(rd), 32'hA5A5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
